// File: rtl/arduino_uart_rx.sv
// rtl/arduino_uart_rx.sv - 8N1 UART receiver that delivers Arduino mode commands
//
// Purpose:
//   Receives 8N1 serial bytes from an Arduino and presents the last correctly
//   framed byte as a held command for mode_select.
//
// Ports:
//   clk             input   1  system clock, rising edge
//   reset           input   1  synchronous, active-high
//   uart_rx_in      input   1  asynchronous serial line, idle high
//   arduino_command output  8  last good byte, 8'hAA after reset
//   command_valid   output  1  one-cycle pulse when arduino_command updates
//   frame_error     output  1  one-cycle pulse when a stop bit samples low
//   rx_busy         output  1  high while a byte is being received
module arduino_uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx_in,
  output logic [7:0] arduino_command,
  output logic       command_valid,
  output logic       frame_error,
  output logic       rx_busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [7:0]    cmd_nxt;
  logic          valid_nxt;
  logic          ferr_nxt;

  logic          sync1;
  logic          rx_s;
  logic          rx_prev;
  // sync_vld marks when rx_s carries a real line sample rather than the
  // reset value; armed is set once the line has genuinely been seen high.
  // Together they stop a line held low through reset from looking like a
  // falling edge when reset releases.
  logic [1:0]    sync_vld;
  logic          armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      sync_vld <= 2'b00;
      armed    <= 1'b0;
    end else begin
      sync1    <= uart_rx_in;
      rx_s     <= sync1;
      rx_prev  <= rx_s;
      sync_vld <= {sync_vld[0], 1'b1};
      armed    <= armed | (sync_vld[1] & rx_s);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      idx             <= 3'd0;
      shreg           <= 8'h00;
      arduino_command <= 8'hAA;
      command_valid   <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      idx             <= idx_nxt;
      shreg           <= shreg_nxt;
      arduino_command <= cmd_nxt;
      command_valid   <= valid_nxt;
      frame_error     <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    cmd_nxt   = arduino_command;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // Edge detect needs a high-to-low transition, so a held-low line
        // or break cannot retrigger until the line returns high.
        if (armed && rx_prev && !rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            idx_nxt   = 3'd0;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_s, shreg[7:1]};
          idx_nxt   = idx + 3'd1;
          if (idx == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (rx_s) begin
            cmd_nxt   = shreg;
            valid_nxt = 1'b1;
          end else begin
            ferr_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_arduino_uart_rx.sv
// tb/tb_arduino_uart_rx.sv - scoreboard bench for arduino_uart_rx
//
// Purpose:
//   Drives 8N1 frames (directed and random) into arduino_uart_rx and checks
//   every command_valid / frame_error pulse against queued expectations.
//
// Ports: none (top-level bench).
module tb_arduino_uart_rx;

  localparam int C       = 16;
  localparam int LATENCY = 2 + 1 + C / 2 + 9 * C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rx_in = 1'b1;
  logic [7:0] arduino_command;
  logic       command_valid;
  logic       frame_error;
  logic       rx_busy;

  arduino_uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk             (clk),
    .reset           (reset),
    .uart_rx_in      (uart_rx_in),
    .arduino_command (arduino_command),
    .command_valid   (command_valid),
    .frame_error     (frame_error),
    .rx_busy         (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] cmd;
    int         t0;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_cmd = 8'hAA;
  int         tests = 0;
  int         failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model of a frame: a good stop bit makes the byte the new command, a low
  // stop bit reports an error and the command stays as it was.
  task automatic send_byte(input logic [7:0] d, input bit good);
    exp_t e;
    e.err = !good;
    e.cmd = good ? d : model_cmd;
    e.t0  = cyc;
    exp_q.push_back(e);
    if (good) model_cmd = d;
    uart_rx_in = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      uart_rx_in = d[i];
      tick(C);
    end
    uart_rx_in = good;
    tick(C);
    uart_rx_in = 1'b1;
  endtask

  initial begin : monitor
    bit   prev_pulse;
    exp_t e;
    int   lat;
    prev_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && (command_valid || frame_error)) begin
        check("pulse_exclusive", 32'(command_valid & frame_error), 32'd0);
        check("pulse_not_consecutive", 32'(prev_pulse), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {31'd0, command_valid}, {31'd0, frame_error});
          tests++;
          failed++;
          $display("FAIL unexpected_pulse: valid=%0b ferr=%0b cmd=%0h", command_valid, frame_error, arduino_command);
        end else begin
          e   = exp_q.pop_front();
          lat = cyc - e.t0;
          check("pulse_kind_valid", 32'(command_valid), 32'(!e.err));
          check("command_value", 32'(arduino_command), 32'(e.cmd));
          check("latency_in_window", 32'((lat >= LATENCY - 1) && (lat <= LATENCY + 1)), 32'd1);
        end
      end
      prev_pulse = command_valid | frame_error;
    end
  end

  initial begin : stimulus
    logic [7:0] d;
    bit         good;
    int         gap;
    int         waited;

    tick(4);
    check("reset_command", 32'(arduino_command), 32'hAA);
    check("reset_valid", 32'(command_valid), 32'd0);
    check("reset_ferr", 32'(frame_error), 32'd0);
    check("reset_busy", 32'(rx_busy), 32'd0);
    reset = 1'b0;
    tick(2 * C);

    send_byte(8'h00, 1'b1);
    tick(2 * C);

    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    tick(2 * C);

    send_byte(8'h3C, 1'b0);
    tick(2 * C);

    uart_rx_in = 1'b0;
    tick(5);
    uart_rx_in = 1'b1;
    tick(2 * C);
    check("glitch_busy", 32'(rx_busy), 32'd0);
    check("glitch_command", 32'(arduino_command), 32'(model_cmd));

    // Abort a byte partway through bit 4 with reset, releasing with the line low.
    uart_rx_in = 1'b0;
    tick(C);
    d = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      uart_rx_in = d[i];
      tick(C);
    end
    uart_rx_in = d[4];
    tick(C / 2);
    check("midbyte_busy_before_reset", 32'(rx_busy), 32'd1);
    reset = 1'b1;
    tick(3);
    model_cmd = 8'hAA;
    check("midreset_command", 32'(arduino_command), 32'hAA);
    check("midreset_busy", 32'(rx_busy), 32'd0);
    reset = 1'b0;
    tick(2 * C);
    check("low_after_reset_busy", 32'(rx_busy), 32'd0);
    uart_rx_in = 1'b1;
    tick(2 * C);
    check("after_reset_command", 32'(arduino_command), 32'hAA);
    send_byte(8'hFF, 1'b1);
    tick(2 * C);

    // Break: one falling edge gives at most one frame error.
    begin
      exp_t e;
      e.err = 1'b1;
      e.cmd = model_cmd;
      e.t0  = cyc;
      exp_q.push_back(e);
    end
    uart_rx_in = 1'b0;
    tick(30 * C);
    check("break_busy_idle", 32'(rx_busy), 32'd0);
    uart_rx_in = 1'b1;
    tick(2 * C);
    send_byte(8'h81, 1'b1);
    tick(2 * C);

    for (int n = 0; n < 20; n++) begin
      d    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      send_byte(d, good);
      gap = $urandom_range(0, 2);
      if (!good && gap == 0) gap = 1;
      tick(gap * C);
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 400) begin
      tick(1);
      waited++;
    end
    check("all_expected_seen", 32'(exp_q.size()), 32'd0);
    tick(C);
    check("final_busy", 32'(rx_busy), 32'd0);
    check("final_command", 32'(arduino_command), 32'(model_cmd));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
